// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: synchronise, debounce symmetrically, and emit
// one-cycle press/release/long-press pulses per channel.
module debounce_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 10,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned ACTIVE_LOW_IN = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
  localparam logic            InvIn  = (ACTIVE_LOW_IN != 0);

  logic [CHANNELS-1:0]           sync1_q, sync2_q;
  logic [CHANNELS-1:0]           level_q, level_d;
  logic [CHANNELS-1:0]           press_q, release_q;
  logic [CHANNELS-1:0][CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw ^ {CHANNELS{InvIn}};
      sync2_q <= sync1_q;
    end
  end

  // Any sample matching the current level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= level_d & ~level_q;
      release_q <= ~level_d & level_q;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  if (HOLD_CYCLES == 0) begin : g_no_hold
    assign btn_long = '0;
  end else begin : g_hold
    localparam int unsigned      HoldW   = $clog2(HOLD_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

    logic [CHANNELS-1:0][HoldW-1:0] hold_q, hold_d;
    logic [CHANNELS-1:0]            long_q, long_d;

    // Count only while the level stays high; a release on the reaching edge suppresses the pulse.
    always_comb begin
      hold_d = '0;
      long_d = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (level_q[i] && level_d[i]) begin
          hold_d[i] = (hold_q[i] == HoldMax) ? HoldMax : hold_q[i] + 1'b1;
          long_d[i] = (hold_q[i] == HoldMax - 1'b1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
        long_q <= '0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    assign btn_long = long_q;
  end

endmodule
